// File: rtl/pic_host_driver_if.sv
// PIC-side bus bundle of the host driver: strobes, address, data lanes
// and the INT line. The master modport belongs to the host driver.
interface pic_host_driver_if;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       cs_n;
  logic       wr_n;
  logic       inta_n;
  logic       a0;
  logic       int_in;

  modport master (
    input  d_in, int_in,
    output d_out, d_oe, cs_n, wr_n, inta_n, a0
  );

  modport slave (
    output d_in, int_in,
    input  d_out, d_oe, cs_n, wr_n, inta_n, a0
  );
endinterface

// File: rtl/pic_host_driver.sv
// 8259-style PIC host driver: ICW init writes, INTA handshake, vector capture.
// Optional PIC_HOST_EOI_EN: non-specific EOI (OCW2 0x20) after vec_ack.
module pic_host_driver #(
  parameter int INTA_LOW_CYC = 2,
  parameter int INTA_GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  input  logic [7:0] cfg_icw1,
  input  logic [7:0] cfg_icw2,
  input  logic [7:0] cfg_icw3,
  input  logic [7:0] cfg_icw4,
  input  logic       vec_ack,
  output logic [7:0] vec,
  output logic       vec_valid,
  output logic       busy,
  output logic       init_done,
  pic_host_driver_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD,
    INTA1, GAP, INTA2, VEC_WAIT
  } state_t;

  typedef enum logic [2:0] {
    W_ICW1, W_ICW2, W_ICW3, W_ICW4
`ifdef PIC_HOST_EOI_EN
    , W_EOI
`endif
  } wsel_t;

  localparam int CW = 8;
  localparam logic [CW-1:0] LOW_LAST = CW'(INTA_LOW_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(INTA_GAP_CYC - 1);

  state_t        state, state_nx;
  wsel_t         wsel, wsel_nx;
  logic [CW-1:0] cnt;
  logic [7:0]    icw1, icw2, icw3, icw4;
  logic          ld_cfg, done_set;
  logic          wr_phase;
  logic [7:0]    wdata;
  logic          wa0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wsel      <= W_ICW1;
      cnt       <= '0;
      icw1      <= '0;
      icw2      <= '0;
      icw3      <= '0;
      icw4      <= '0;
      vec       <= '0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      wsel  <= wsel_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + CW'(1);
      if (ld_cfg) begin
        icw1 <= cfg_icw1;
        icw2 <= cfg_icw2;
        icw3 <= cfg_icw3;
        icw4 <= cfg_icw4;
      end
      if (state == INTA2 && cnt == LOW_LAST)
        vec <= bus.d_in;
      if (ld_cfg)
        init_done <= 1'b0;
      else if (done_set)
        init_done <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wsel_nx  = wsel;
    ld_cfg   = 1'b0;
    done_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (init_start) begin
          state_nx = WR_SETUP;
          wsel_nx  = W_ICW1;
          ld_cfg   = 1'b1;
        end else if (bus.int_in && init_done) begin
          state_nx = INTA1;
        end
      end
      WR_SETUP:  state_nx = WR_STROBE;
      WR_STROBE: state_nx = WR_HOLD;
      WR_HOLD: begin
        state_nx = WR_SETUP;
        // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1
        unique case (wsel)
          W_ICW1: wsel_nx = W_ICW2;
          W_ICW2: begin
            if (!icw1[1])
              wsel_nx = W_ICW3;
            else if (icw1[0])
              wsel_nx = W_ICW4;
            else begin
              state_nx = IDLE;
              done_set = 1'b1;
            end
          end
          W_ICW3: begin
            if (icw1[0])
              wsel_nx = W_ICW4;
            else begin
              state_nx = IDLE;
              done_set = 1'b1;
            end
          end
          W_ICW4: begin
            state_nx = IDLE;
            done_set = 1'b1;
          end
          default: state_nx = IDLE;
        endcase
      end
      INTA1: if (cnt == LOW_LAST) state_nx = GAP;
      GAP:   if (cnt == GAP_LAST) state_nx = INTA2;
      INTA2: if (cnt == LOW_LAST) state_nx = VEC_WAIT;
      VEC_WAIT: begin
        if (vec_ack) begin
`ifdef PIC_HOST_EOI_EN
          state_nx = WR_SETUP;
          wsel_nx  = W_EOI;
`else
          state_nx = IDLE;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wdata = 8'h00;
    wa0   = 1'b0;
    unique case (wsel)
      W_ICW1: begin wdata = icw1; wa0 = 1'b0; end
      W_ICW2: begin wdata = icw2; wa0 = 1'b1; end
      W_ICW3: begin wdata = icw3; wa0 = 1'b1; end
      W_ICW4: begin wdata = icw4; wa0 = 1'b1; end
`ifdef PIC_HOST_EOI_EN
      W_EOI:  begin wdata = 8'h20; wa0 = 1'b0; end
`endif
      default: begin wdata = 8'h00; wa0 = 1'b0; end
    endcase
  end

  // Strobes decode straight from state so async reset clears them at once
  assign wr_phase   = (state == WR_SETUP) || (state == WR_STROBE) ||
                      (state == WR_HOLD);
  assign bus.cs_n   = !wr_phase;
  assign bus.d_oe   = wr_phase;
  assign bus.wr_n   = (state != WR_STROBE);
  assign bus.inta_n = !((state == INTA1) || (state == INTA2));
  assign bus.d_out  = wr_phase ? wdata : 8'h00;
  assign bus.a0     = wr_phase ? wa0 : 1'b0;
  assign busy       = (state != IDLE);
  assign vec_valid  = (state == VEC_WAIT);

endmodule
